mac_tx_framer: RTL
==================

Name: mac_tx_framer

Overview:
Transmit-side frame controller for the MAC byte datapath. It accepts a payload stream (Avalon-ST style, 8-bit) and drives a line-side stream of one byte per clock, with no backpressure. It sequences the shared CRC-32 engine through its crc_init/crc_en/crc_data interface. It emits preamble and SFD, forwards the payload, pads short frames, appends the FCS and enforces the inter-frame gap.

Parameters:
P_PREAMBLE_LEN, 7, number of 0x55 preamble bytes before the SFD (0xD5)
P_MIN_FRAME, 60, minimum payload+pad bytes before FCS; shorter frames are padded with 0x00
P_MAX_FRAME, 1514, maximum payload bytes; exceeding it aborts the frame
P_IFG, 12, idle cycles after the last FCS/abort byte before the next preamble

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_startofpacket  in  1  first payload byte
in_endofpacket  in  1  last payload byte
in_valid  in  1  in_data valid
in_data  in  8  payload byte
in_error  in  1  upstream error on this byte
in_ready  out  1  byte accepted when in_valid & in_ready
crc_init  out  1  reset CRC engine to all-ones (combinational)
crc_en  out  1  CRC engine consumes crc_data this cycle (combinational)
crc_data  out  8  byte to CRC engine (combinational)
crc_value  in  32  engine CRC register, transmit bit order; reflects every byte enabled up to the previous cycle
out_startofpacket  out  1  first preamble byte
out_endofpacket  out  1  last FCS byte, or the abort byte
out_valid  out  1  out_data valid
out_data  out  8  line byte
out_error  out  1  frame is corrupt

Behaviour:
- Reset: state IDLE; all out_* = 0; in_ready = 0; crc_init = 0; crc_en = 0; counters cleared. Reset mid-frame truncates immediately, with no tail bytes and no FCS.
- out_* are registered: each byte is decided in cycle N and appears at out_* in cycle N+1.
- crc_en/crc_data are asserted in the same cycle N that the byte is decided, so crc_value in cycle N+1 includes that byte.
- in_ready = (state==PAYLOAD) | (state==IDLE & ~in_startofpacket). Non-SOP bytes arriving in IDLE are silently discarded.
- States:
  - IDLE: on in_valid & in_startofpacket (byte not consumed), go to PREAMBLE.
  - PREAMBLE: emits P_PREAMBLE_LEN bytes of 0x55; out_startofpacket=1 on the first.
  - SFD: emits 0xD5; crc_init=1 for this cycle only.
  - PAYLOAD: each accepted byte is forwarded to out and to the CRC (crc_en=1); byte counter increments.
    - In-band in_error: sets a sticky frame error that is ORed into out_error for all remaining bytes of the frame.
    - Byte with in_endofpacket: go to PAD if counter+1 < P_MIN_FRAME, else go to FCS.
  - PAD: emits 0x00 with crc_en=1 until the counter reaches P_MIN_FRAME, then go to FCS.
  - FCS: in the first cycle, latch ~crc_value; emit bits [7:0], [15:8], [23:16], [31:24] on four consecutive cycles; out_endofpacket=1 on the last; crc_en=0. Then go to IFG.
  - IFG: out_valid=0 for P_IFG cycles, then go to IDLE.
- Underrun: in_valid=0 in PAYLOAD means no byte is accepted that cycle. Emit 0x00 with out_valid=1, out_error=1, out_endofpacket=1, then go to IFG. No FCS is sent.
- Oversize: a payload byte that would be byte P_MAX_FRAME+1 is accepted and dropped. Emit the abort byte (as for underrun). Then in_ready stays 1 in a DRAIN state, discarding bytes through in_endofpacket, after which go to IFG. The IFG count starts at the abort byte.
- out_valid=1 in every cycle from the first preamble byte through the last FCS/abort byte; out_valid=0 otherwise.
- Byte counter is 11 bits and saturates; it is compared against P_MIN_FRAME and P_MAX_FRAME.

Optional Feature:
TX_STATS_EN:
- Defined: adds output ports stat_frames[31:0] (incremented on each completed FCS) and stat_aborts[15:0] (incremented on each underrun/oversize abort). Both wrap, and both clear on reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- 64-byte payload 0x00..0x3F, contiguous valid -> out: 7x 0x55, 0xD5, 64 payload bytes, 4 FCS bytes; FCS matches the reference CRC-32 model; CRC of payload+FCS equals residue 0xC704DD7B; then 12 idle cycles.
- 1-byte frame (SOP+EOP, data 0xAB) -> 0xAB followed by 59 bytes of 0x00, then FCS; total out_valid cycles = 8+60+4 = 72.
- in_valid deasserted after payload byte 20 -> abort byte 0x00 with out_error=1 and out_endofpacket=1, no FCS; next frame's preamble starts ≥12 cycles later.
- 1515-byte payload -> abort after 1514 bytes; remaining input drained with in_ready=1 until EOP; out_error=1 on the abort byte.
- in_error on payload byte 5 -> frame completes with FCS; out_error=1 from byte 5 through the last FCS byte.
- rst_n low for 1 cycle during payload -> next cycle all out_*=0, in_ready=0; a new SOP is then accepted and produces a clean frame.

Source files
------------

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: MAC transmit framer (preamble, SFD, payload, pad, FCS, IFG).
// Define TX_STATS_EN to add the stat_frames/stat_aborts counter ports.
module mac_tx_framer #(
    parameter int P_PREAMBLE_LEN = 7,
    parameter int P_MIN_FRAME    = 60,
    parameter int P_MAX_FRAME    = 1514,
    parameter int P_IFG          = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_error,
    output logic        in_ready,
    output logic        crc_init,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_value,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_error
`ifdef TX_STATS_EN
    ,
    output logic [31:0] stat_frames,
    output logic [15:0] stat_aborts
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SFD   = 3'd2;
    localparam logic [2:0] S_PAY   = 3'd3;
    localparam logic [2:0] S_PAD   = 3'd4;
    localparam logic [2:0] S_FCS   = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;
    localparam logic [2:0] S_IFG   = 3'd7;

    localparam logic [10:0] L_MIN = 11'(P_MIN_FRAME);
    localparam logic [10:0] L_MAX = 11'(P_MAX_FRAME);
    localparam logic [15:0] L_PRE = 16'(P_PREAMBLE_LEN - 1);
    localparam logic [15:0] L_IFG = 16'(P_IFG - 1);

    logic [2:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] cnt_inc;
    logic [15:0] sub_q, sub_d;
    logic        err_q, err_d;
    logic [31:0] fcs_q, fcs_d;

    logic        vld_q, vld_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [7:0]  dat_q, dat_d;
    logic        oer_q, oer_d;

    logic        rdy;
    logic        cinit;
    logic        cen;
    logic [7:0]  cdat;
    logic        abort_c;
    logic        done_c;

    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    // Combinational control outputs are held low while reset is asserted.
    assign in_ready = rst_n & rdy;
    assign crc_init = rst_n & cinit;
    assign crc_en   = rst_n & cen;
    assign crc_data = cdat;

    assign out_valid         = vld_q;
    assign out_startofpacket = sop_q;
    assign out_endofpacket   = eop_q;
    assign out_data          = dat_q;
    assign out_error         = oer_q;

    // Next-state, next line byte and CRC engine sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        err_d   = err_q;
        fcs_d   = fcs_q;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        dat_d   = 8'h00;
        oer_d   = 1'b0;
        rdy     = 1'b0;
        cinit   = 1'b0;
        cen     = 1'b0;
        cdat    = 8'h00;
        abort_c = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rdy = ~in_startofpacket;
                if (in_valid && in_startofpacket) begin
                    state_d = S_PRE;
                    sub_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_PRE: begin
                vld_d = 1'b1;
                dat_d = 8'h55;
                sop_d = (sub_q == '0);
                if (sub_q >= L_PRE) begin
                    state_d = S_SFD;
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + 16'd1;
                end
            end
            S_SFD: begin
                vld_d   = 1'b1;
                dat_d   = 8'hD5;
                cinit   = 1'b1;
                state_d = S_PAY;
            end
            S_PAY: begin
                rdy = 1'b1;
                if (!in_valid) begin
                    abort_c = 1'b1;
                    state_d = S_IFG;
                    sub_d   = '0;
                end else if (cnt_q >= L_MAX) begin
                    abort_c = 1'b1;
                    state_d = in_endofpacket ? S_IFG : S_DRAIN;
                    sub_d   = '0;
                end else begin
                    vld_d = 1'b1;
                    dat_d = in_data;
                    oer_d = err_q | in_error;
                    err_d = err_q | in_error;
                    cen   = 1'b1;
                    cdat  = in_data;
                    cnt_d = cnt_inc;
                    if (in_endofpacket) begin
                        state_d = (cnt_inc < L_MIN) ? S_PAD : S_FCS;
                        sub_d   = '0;
                    end
                end
            end
            S_PAD: begin
                vld_d = 1'b1;
                oer_d = err_q;
                cen   = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc >= L_MIN) begin
                    state_d = S_FCS;
                    sub_d   = '0;
                end
            end
            S_FCS: begin
                vld_d = 1'b1;
                oer_d = err_q;
                case (sub_q[1:0])
                    2'd0: begin
                        dat_d = ~crc_value[7:0];
                        fcs_d = ~crc_value;
                    end
                    2'd1: dat_d = fcs_q[15:8];
                    2'd2: dat_d = fcs_q[23:16];
                    default: dat_d = fcs_q[31:24];
                endcase
                if (sub_q[1:0] == 2'd3) begin
                    eop_d   = 1'b1;
                    done_c  = 1'b1;
                    state_d = S_IFG;
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + 16'd1;
                end
            end
            S_DRAIN: begin
                rdy = 1'b1;
                // Drain cycles already count toward the gap after the abort byte.
                if (in_valid && in_endofpacket) begin
                    if (sub_q >= L_IFG) begin
                        state_d = S_IDLE;
                        sub_d   = '0;
                    end else begin
                        state_d = S_IFG;
                        sub_d   = sub_q + 16'd1;
                    end
                end else if (sub_q < L_IFG) begin
                    sub_d = sub_q + 16'd1;
                end
            end
            S_IFG: begin
                if (sub_q >= L_IFG) begin
                    state_d = S_IDLE;
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_c) begin
            vld_d = 1'b1;
            eop_d = 1'b1;
            oer_d = 1'b1;
            dat_d = 8'h00;
        end
    end

    // State, counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            err_q   <= 1'b0;
            fcs_q   <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            dat_q   <= 8'h00;
            oer_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
            fcs_q   <= fcs_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            dat_q   <= dat_d;
            oer_q   <= oer_d;
        end
    end

`ifdef TX_STATS_EN
    logic [31:0] frames_q;
    logic [15:0] aborts_q;

    assign stat_frames = frames_q;
    assign stat_aborts = aborts_q;

    // Wrapping counters of completed and aborted frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_q <= '0;
            aborts_q <= '0;
        end else begin
            if (done_c) frames_q <= frames_q + 32'd1;
            if (abort_c) aborts_q <= aborts_q + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = done_c;
`endif

endmodule
